ram_port_seq: RTL and testbench

Single-clock burst sequencer that acts as the initiator on one port of the 16x8 dual-port RAM. It accepts a burst command (direction, start address, length) from a host. Write bursts are streamed from a valid/ready input into the RAM port; read bursts are streamed from the RAM port to a valid/ready output, with backpressure absorbed by a small return FIFO. One instance drives one RAM port (a, or b), clocked by that port's clock.

---
 rtl/ram_port_seq_pkg.sv | 13 +
 rtl/ram_rd_fifo.sv | 47 ++++
 rtl/ram_port_seq.sv | 119 +++++++++++
 tb/tb_ram_port_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_seq_pkg.sv
// ram_port_seq_pkg: shared types and sizing for the RAM port burst sequencer
package ram_port_seq_pkg;
    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 4;
    localparam int READ_LAT_DEF = 1;
    localparam int FIFO_DEPTH   = READ_LAT_DEF + 2;

    typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

    function automatic int fifo_depth(input int read_lat);
        return read_lat + 2;
    endfunction
endpackage

// File: rtl/ram_rd_fifo.sv
// ram_rd_fifo: small synchronous FIFO absorbing read-return backpressure
module ram_rd_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 3,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk0,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;

    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
    assign dout  = empty ? '0 : mem[rptr];

    // pointers wrap at DEPTH-1 since the depth need not be a power of two
    always_ff @(posedge clk0 or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (pop && !empty)
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop && !empty);
        end
    end

    // storage is left unreset; the empty flag masks stale contents
    always_ff @(posedge clk0) begin
        if (push)
            mem[wptr] <= din;
    end

    overflow_a: assert property (@(posedge clk0) disable iff (!rst) !(push && full));
endmodule

// File: rtl/ram_port_seq.sv
// ram_port_seq: burst sequencer driving one port of a 16x8 dual-port RAM
module ram_port_seq
    import ram_port_seq_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic              clk0,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done
);
    localparam int DEPTH = fifo_depth(READ_LAT);
    localparam int CW    = $clog2(DEPTH + 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_cnt, beat_cnt;
    logic [READ_LAT:0] rd_sh;
    logic [CW-1:0]     fifo_count;
    logic              cmd_fire, wr_fire, rd_issue, pop, fifo_empty, fifo_full;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign wr_fire  = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign rd_valid = !fifo_empty;
    assign busy     = state != IDLE;
    // a pop on this edge frees a slot, which keeps reads at one beat per cycle
    assign rd_issue = (state == RD) &&
                      (int'(fifo_count) + $countones(rd_sh) - int'(pop) < DEPTH);

    // next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = cmd_fire ? (cmd_wr ? WR : RD) : IDLE;
            WR:      state_nx = (wr_fire && beat_cnt == '0) ? IDLE : WR;
            RD:      state_nx = (rd_issue && beat_cnt == '0) ? DRAIN : RD;
            DRAIN:   state_nx = (fifo_empty && rd_sh == '0) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // state register and registered handshake/status outputs
    always_ff @(posedge clk0 or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            wr_ready  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cmd_ready <= state_nx == IDLE;
            wr_ready  <= state_nx == WR;
            done      <= (state != IDLE) && (state_nx == IDLE);
        end
    end

    // burst address and remaining-beat counters
    always_ff @(posedge clk0 or negedge rst) begin
        if (!rst) begin
            addr_cnt <= '0;
            beat_cnt <= '0;
        end else if (cmd_fire) begin
            addr_cnt <= cmd_addr;
            beat_cnt <= cmd_len;
        end else if (wr_fire || rd_issue) begin
            addr_cnt <= addr_cnt + 1'b1;
            beat_cnt <= beat_cnt - 1'b1;
        end
    end

    // registered RAM port drive plus in-flight read tracking
    always_ff @(posedge clk0 or negedge rst) begin
        if (!rst) begin
            ram_we   <= 1'b0;
            ram_re   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            rd_sh    <= '0;
        end else begin
            ram_we <= wr_fire;
            ram_re <= rd_issue;
            rd_sh  <= {rd_sh[READ_LAT-1:0], rd_issue};
            if (wr_fire || rd_issue)
                ram_addr <= addr_cnt;
            if (wr_fire)
                ram_din <= wr_data;
        end
    end

    ram_rd_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk0  (clk0),
        .rst   (rst),
        .push  (rd_sh[READ_LAT]),
        .din   (ram_dout),
        .pop   (pop),
        .dout  (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_ram_port_seq.sv
// tb_ram_port_seq: randomized scoreboard bench for ram_port_seq with a RAM model
module tb_ram_port_seq;
    logic       clk0, rst;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [3:0] cmd_addr, cmd_len;
    logic [7:0] wr_data, rd_data, ram_din, ram_dout;
    logic       wr_valid, wr_ready, rd_valid, rd_ready;
    logic [3:0] ram_addr;
    logic       ram_we, ram_re, busy, done;

    ram_port_seq dut (
        .clk0(clk0), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_re(ram_re),
        .ram_dout(ram_dout), .busy(busy), .done(done)
    );

    int checks = 0, errors = 0;
    int done_cnt = 0, exp_done = 0;
    int issued = 0, popped = 0;
    int mode = 0;
    logic [7:0]  ram [16];
    logic [7:0]  ref_mem [16];
    logic [7:0]  wdata [16];
    logic [11:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [3:0]  exp_ra_q[$];

    initial begin
        clk0 = 0;
        forever #5 clk0 = ~clk0;
    end

    // synchronous RAM port, one cycle read latency
    always @(posedge clk0) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= ram[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // read-stream backpressure: always ready, 1,0,0,1 pattern, or random
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph = 0;
        rd_ready = 1;
        forever begin
            @(posedge clk0);
            #1;
            ph++;
            rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[ph % 4] : 1'($urandom_range(0, 1));
        end
    end

    // monitor: pops expectations whenever the DUT presents RAM or stream activity
    always @(negedge clk0) begin
        if (!rst) begin
            issued = 0;
            popped = 0;
        end else begin
            if (ram_we && ram_re) chk("we_re_exclusive", {ram_we, ram_re}, 2'b10);
            if (ram_we) begin
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ram_we_extra: addr %0h din %0h with nothing expected", ram_addr, ram_din);
                end else chk("ram_write", {ram_addr, ram_din}, exp_wr_q.pop_front());
            end
            if (ram_re) begin
                issued++;
                chk("inflight_plus_occ_le3", 32'(issued - popped <= 3), 1);
                if (exp_ra_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ram_re_extra: addr %0h with nothing expected", ram_addr);
                end else chk("ram_read_addr", ram_addr, exp_ra_q.pop_front());
            end
            if (rd_valid && rd_ready) begin
                popped++;
                if (exp_rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_extra_beat: data %0h with nothing expected", rd_data);
                end else chk("rd_data", rd_data, exp_rd_q.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    task automatic wait_done();
        int n = 0;
        while (done_cnt < exp_done && n < 500) begin
            @(negedge clk0);
            n++;
        end
        repeat (2) @(negedge clk0);
        chk("done_count", done_cnt, exp_done);
        @(posedge clk0);
        #1;
    endtask

    task automatic send_cmd(input bit wr, input logic [3:0] a, input logic [3:0] l);
        int n = 0;
        cmd_wr = wr; cmd_addr = a; cmd_len = l; cmd_valid = 1;
        @(negedge clk0);
        while (!cmd_ready && n < 300) begin
            @(negedge clk0);
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk0);
        #1;
        cmd_valid = 0;
    endtask

    task automatic write_burst(input logic [3:0] a, input logic [3:0] l, input bit gaps,
                               input bit hold, input logic [3:0] ha, input logic [3:0] hl);
        send_cmd(1, a, l);
        if (hold) begin
            cmd_valid = 1; cmd_wr = 0; cmd_addr = ha; cmd_len = hl;
        end
        for (int i = 0; i <= int'(l); i++) begin
            logic [3:0] wa;
            int n;
            wa = a + 4'(i);
            if (gaps && $urandom_range(0, 2) == 0) begin
                wr_valid = 0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk0);
                    #1;
                end
            end
            wr_valid = 1;
            wr_data = wdata[i];
            n = 0;
            @(negedge clk0);
            while (!wr_ready && n < 50) begin
                @(negedge clk0);
                n++;
            end
            chk("wr_ready_wait", wr_ready, 1);
            if (hold) chk("busy_reject_cmd_ready", cmd_ready, 0);
            exp_wr_q.push_back({wa, wdata[i]});
            ref_mem[wa] = wdata[i];
            @(posedge clk0);
            #1;
        end
        wr_valid = 0;
        @(negedge clk0);
        chk("done_with_last_we", {done, ram_we, busy}, 3'b110);
        exp_done++;
        if (hold) begin
            chk("cmd_ready_at_done", cmd_ready, 1);
            for (int j = 0; j <= int'(hl); j++) begin
                exp_rd_q.push_back(ref_mem[ha + 4'(j)]);
                exp_ra_q.push_back(ha + 4'(j));
            end
            exp_done++;
            @(posedge clk0);
            #1;
            cmd_valid = 0;
        end
        wait_done();
        chk("wr_q_empty", exp_wr_q.size(), 0);
        if (hold) chk("held_rd_q_empty", exp_rd_q.size(), 0);
    endtask

    task automatic read_burst(input logic [3:0] a, input logic [3:0] l, input bit lat);
        for (int j = 0; j <= int'(l); j++) begin
            exp_rd_q.push_back(ref_mem[a + 4'(j)]);
            exp_ra_q.push_back(a + 4'(j));
        end
        send_cmd(0, a, l);
        if (lat) begin
            int n = 0;
            do begin
                @(negedge clk0);
                n++;
            end while (!rd_valid && n < 20);
            chk("first_rd_valid_latency", n, 4);
        end
        exp_done++;
        wait_done();
        chk("rd_q_empty", exp_rd_q.size(), 0);
        chk("busy_after_read", busy, 0);
    endtask

    function automatic logic [26:0] all_outs();
        return {cmd_ready, wr_ready, rd_valid, rd_data, ram_addr, ram_din, ram_we, ram_re, busy, done};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 0; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_len = 0;
        wr_valid = 0; wr_data = 0;
        repeat (3) @(posedge clk0);
        #1;
        chk("reset_outputs", all_outs(), 0);
        rst = 1;
        @(negedge clk0);
        chk("cmd_ready_before_first_edge", cmd_ready, 0);
        @(negedge clk0);
        chk("cmd_ready_after_release", {cmd_ready, busy}, 2'b10);
        @(posedge clk0);
        #1;

        wdata[0] = 8'h01; wdata[1] = 8'h03; wdata[2] = 8'h07; wdata[3] = 8'h1A;
        write_burst(4'hA, 4'd3, 0, 0, 0, 0);
        read_burst(4'hA, 4'd3, 1);

        for (int i = 0; i < 16; i++) wdata[i] = 8'($urandom);
        write_burst(4'hF, 4'd15, 1, 0, 0, 0);
        mode = 1;
        read_burst(4'hF, 4'd15, 0);
        mode = 0;

        for (int i = 0; i < 16; i++) wdata[i] = 8'($urandom);
        write_burst(4'h2, 4'd5, 1, 1, 4'h2, 4'd5);

        mode = 2;
        for (int k = 0; k < 20; k++) begin
            logic [3:0] a, l;
            a = 4'($urandom);
            l = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) wdata[i] = 8'($urandom);
                write_burst(a, l, 1, 0, 0, 0);
            end else read_burst(a, l, 0);
        end
        mode = 0;

        begin
            int n = 0;
            for (int j = 0; j < 8; j++) begin
                exp_rd_q.push_back(ref_mem[4'(j)]);
                exp_ra_q.push_back(4'(j));
            end
            send_cmd(0, 4'h0, 4'd7);
            while (popped < 5 && n < 100) begin
                @(negedge clk0);
                n++;
            end
            chk("mid_read_pops_seen", 32'(popped >= 5), 1);
            @(posedge clk0);
            #2;
            rst = 0;
            #1;
            chk("reset_mid_read_outputs", all_outs(), 0);
            exp_rd_q.delete();
            exp_ra_q.delete();
            exp_wr_q.delete();
            repeat (2) @(posedge clk0);
            #3;
            rst = 1;
            @(negedge clk0);
            chk("cmd_ready_pre_edge_after_reset", cmd_ready, 0);
            @(negedge clk0);
            chk("idle_after_reset", {cmd_ready, busy, done}, 3'b100);
            @(posedge clk0);
            #1;
        end
        wdata[0] = 8'h5C; wdata[1] = 8'hA3;
        write_burst(4'h3, 4'd1, 0, 0, 0, 0);
        read_burst(4'h3, 4'd1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
